pop_sorter_topk: RTL and testbench
==================================

Name: pop_sorter_topk

Overview:
- Parametrised successor to the population sorter in the genetic run pipeline.
- Captures N packed fitness/distance values on start and performs one selection per cycle to emit the K best entries, as index plus value, best first.
- Supports ascending (smallest first) or descending order, with a deterministic lowest-index tie-break.
- Sits between fitness evaluation and parent selection/crossover.

Parameters:
- N, 50, population size (number of input entries), 2..64
- DW, 12, width of each distance/fitness value
- IW, 6, index width; must satisfy 2**IW >= N
- K, 50, number of ranked entries produced, 1..N

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  sample `in` and `descending`, begin a sort (accepted in IDLE or DONE)
- descending  in  1  0 = smallest value first, 1 = largest first; latched at start
- in  in  N*DW  packed values, entry i = in[DW*i +: DW]
- sorted_idx  out  K*IW  rank r index = sorted_idx[IW*r +: IW], r=0 is best
- sorted_val  out  K*DW  rank r value = sorted_val[DW*r +: DW]
- busy  out  1  high while sorting (SELECT state)
- done  out  1  high in DONE; results stable and valid

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, counter=0, all value regs=0, valid mask all 0.
  - sorted_idx=0, sorted_val=0, busy=0, done=0.
  - rst has priority over start and aborts any sort in progress.
- States: IDLE, SELECT, DONE.
  - IDLE: start=1 → latch all N values, set valid mask all 1, latch descending, counter=0, go SELECT. Otherwise stay.
  - SELECT: each cycle, combinationally scan entries with valid=1 for the best value.
    - Best means minimum (descending=0) or maximum (descending=1).
    - Ties go to the lowest index (strict compare while scanning upward).
    - Write rank[counter] = index and value, clear that entry's valid bit, counter+1.
    - Go to DONE when counter == K-1 on the writing cycle; else stay.
  - DONE: done=1; outputs held. start=1 → reload exactly as in IDLE and go SELECT (done drops next cycle). Otherwise stay.
- Selection uses the valid mask, not a sentinel value. Entries equal to all-ones (2**DW-1) or zero are ranked correctly.
- The scan seed is the first valid entry, so no out-of-range sentinel is needed. Comparisons are unsigned at full DW width.
- Latency: start sampled at edge T → busy high T+1..T+K; done high from edge T+K+1 (K SELECT cycles).
- start while in SELECT is ignored; the current sort completes.
- Outputs during SELECT: ranks 0..counter-1 are updated progressively; ranks >= counter keep their previous contents. Consumers use outputs only when done=1.
- Ranks never repeat an index, and all emitted indices are < N.
- descending and in changes after the start edge have no effect until the next start.

Test Plan:
- N=4,K=4,DW=12, in={entry0=30,1=10,2=20,3=5}, descending=0 → sorted_idx ranks {3,1,2,0}, vals {5,10,20,30}; done at start edge+5; busy high for exactly 4 cycles.
- Same in with descending=1 → idx {0,2,1,3}, vals {30,20,10,5}.
- Ties and extremes, N=4: in={4095,7,7,4095}, ascending → idx {1,2,0,3}; descending → idx {0,3,1,2}. Confirms lowest-index tie-break and correct handling of all-ones values.
- Top-K, defaults N=50 with K=3 override, entry i = 1000-i*3 → idx {49,48,47}, vals {853,856,859}; done at start+4.
- Reset mid-sort: rst at 2nd SELECT cycle → next cycle state IDLE, busy=0, done=0, outputs=0. A following start completes a full correct sort.
- Restart from DONE: after a completed sort, pulse start with new data; verify start in SELECT is ignored; new results match a reference model; 1000 random vectors at default parameters checked against a software stable sort.

Source files
------------

// File: rtl/pop_sorter_topk.sv
// Top-K population sorter: latches N values on start, then emits one ranked entry per cycle
// (index + value, best first) using a valid mask and lowest-index tie-break.
module pop_sorter_topk #(
    parameter int N  = 50,
    parameter int DW = 12,
    parameter int IW = 6,
    parameter int K  = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            descending,
    input  logic [N*DW-1:0] in,
    output logic [K*IW-1:0] sorted_idx,
    output logic [K*DW-1:0] sorted_val,
    output logic            busy,
    output logic            done
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   vals_q [N];
    logic [N-1:0]    valid_q;
    logic            desc_q;
    logic [CW-1:0]   cnt_q;
    logic [K*IW-1:0] idx_q;
    logic [K*DW-1:0] val_q;

    logic            load;
    logic            sel;
    logic            last;
    logic            found;
    logic [IW-1:0]   best_idx;
    logic [DW-1:0]   best_val;

    // Seed from the first valid entry; strict compare keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_val = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_q[i] && (!found ||
                (desc_q ? (vals_q[i] > best_val) : (vals_q[i] < best_val)))) begin
                found    = 1'b1;
                best_idx = IW'(i);
                best_val = vals_q[i];
            end
        end
    end

    assign last = (cnt_q == CW'(K - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sel     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                sel = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            desc_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            for (int i = 0; i < N; i++) begin
                vals_q[i] <= '0;
            end
        end else if (load) begin
            valid_q <= '1;
            desc_q  <= descending;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                vals_q[i] <= in[DW*i +: DW];
            end
        end else if (sel) begin
            // Ranks at or above the counter keep their old contents until written.
            for (int r = 0; r < K; r++) begin
                if (CW'(r) == cnt_q) begin
                    idx_q[IW*r +: IW] <= best_idx;
                    val_q[DW*r +: DW] <= best_val;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (IW'(i) == best_idx) begin
                    valid_q[i] <= 1'b0;
                end
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sorted_idx = idx_q;
    assign sorted_val = val_q;
    assign busy       = (state_q == S_SELECT);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_pop_sorter_topk.sv
// Scoreboard bench for pop_sorter_topk: three instances (N4/K4, N50/K3, N50/K50) against a
// stable-insertion-sort reference model.
module tb_pop_sorter_topk;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N=4, K=4
    logic         startA, descA, busyA, doneA;
    logic [47:0]  inA;
    logic [23:0]  idxA;
    logic [47:0]  valA;
    // Instance B: N=50, K=3
    logic         startB, descB, busyB, doneB;
    logic [599:0] inB;
    logic [17:0]  idxB;
    logic [35:0]  valB;
    // Instance C: defaults N=50, K=50
    logic         startC, descC, busyC, doneC;
    logic [599:0] inC;
    logic [299:0] idxC;
    logic [599:0] valC;

    pop_sorter_topk #(.N(4), .DW(12), .IW(6), .K(4)) dutA (
        .clk(clk), .rst(rst), .start(startA), .descending(descA), .in(inA),
        .sorted_idx(idxA), .sorted_val(valA), .busy(busyA), .done(doneA));
    pop_sorter_topk #(.N(50), .DW(12), .IW(6), .K(3)) dutB (
        .clk(clk), .rst(rst), .start(startB), .descending(descB), .in(inB),
        .sorted_idx(idxB), .sorted_val(valB), .busy(busyB), .done(doneB));
    pop_sorter_topk dutC (
        .clk(clk), .rst(rst), .start(startC), .descending(descC), .in(inC),
        .sorted_idx(idxC), .sorted_val(valC), .busy(busyC), .done(doneC));

    int nvec  = 0;
    int nfail = 0;
    int va [64];

    logic [23:0]  qAi[$];
    logic [47:0]  qAv[$];
    logic [17:0]  qBi[$];
    logic [35:0]  qBv[$];
    logic [299:0] qCi[$];
    logic [599:0] qCv[$];

    function automatic void chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    function automatic bit better(input int a, input int b, input bit d);
        return d ? (a > b) : (a < b);
    endfunction

    // Stable insertion sort: an entry goes before the first strictly worse one.
    function automatic void model(input int v[64], input int n, input int k, input bit d,
                                  output logic [767:0] ev, output logic [383:0] ei);
        int ord[$];
        int p;
        bit hit;
        ord = {};
        for (int i = 0; i < n; i++) begin
            p   = ord.size();
            hit = 1'b0;
            for (int j = 0; j < ord.size(); j++) begin
                if (!hit && better(v[i], v[ord[j]], d)) begin
                    p   = j;
                    hit = 1'b1;
                end
            end
            ord.insert(p, i);
        end
        ev = '0;
        ei = '0;
        for (int r = 0; r < k; r++) begin
            ev[12*r +: 12] = 12'(v[ord[r]]);
            ei[6*r +: 6]   = 6'(ord[r]);
        end
    endfunction

    bit pdA = 1'b0, pdB = 1'b0, pdC = 1'b0;
    always @(negedge clk) begin
        if (doneA && !pdA) begin
            if (qAi.size() == 0) chk("A_unexpected_done", 768'(1), 768'(0));
            else begin
                chk("A_idx", 768'(idxA), 768'(qAi.pop_front()));
                chk("A_val", 768'(valA), 768'(qAv.pop_front()));
            end
        end
        if (doneB && !pdB) begin
            if (qBi.size() == 0) chk("B_unexpected_done", 768'(1), 768'(0));
            else begin
                chk("B_idx", 768'(idxB), 768'(qBi.pop_front()));
                chk("B_val", 768'(valB), 768'(qBv.pop_front()));
            end
        end
        if (doneC && !pdC) begin
            if (qCi.size() == 0) chk("C_unexpected_done", 768'(1), 768'(0));
            else begin
                chk("C_idx", 768'(idxC), 768'(qCi.pop_front()));
                chk("C_val", 768'(valC), 768'(qCv.pop_front()));
            end
        end
        pdA = doneA;
        pdB = doneB;
        pdC = doneC;
    end

    task automatic runA(input bit d);
        logic [767:0] ev;
        logic [383:0] ei;
        int cyc, nb;
        model(va, 4, 4, d, ev, ei);
        qAi.push_back(ei[23:0]);
        qAv.push_back(ev[47:0]);
        for (int i = 0; i < 4; i++) inA[12*i +: 12] = 12'(va[i]);
        descA  = d;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        inA    = '0;
        descA  = ~d;
        cyc = 0; nb = 0;
        while (!doneA && cyc < 20) begin
            if (busyA) nb++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("A_done_latency", 768'(cyc), 768'(4));
        chk("A_busy_cycles", 768'(nb), 768'(4));
        @(posedge clk); #1;
    endtask

    task automatic runB(input bit d);
        logic [767:0] ev;
        logic [383:0] ei;
        int cyc, nb;
        model(va, 50, 3, d, ev, ei);
        qBi.push_back(ei[17:0]);
        qBv.push_back(ev[35:0]);
        for (int i = 0; i < 50; i++) inB[12*i +: 12] = 12'(va[i]);
        descB  = d;
        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        cyc = 0; nb = 0;
        while (!doneB && cyc < 20) begin
            if (busyB) nb++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("B_done_latency", 768'(cyc), 768'(3));
        chk("B_busy_cycles", 768'(nb), 768'(3));
        @(posedge clk); #1;
    endtask

    task automatic loadC(input bit d);
        for (int i = 0; i < 50; i++) inC[12*i +: 12] = 12'(va[i]);
        descC  = d;
        startC = 1'b1;
        @(posedge clk); #1;
        startC = 1'b0;
        inC    = '0;
        descC  = ~d;
    endtask

    task automatic runC(input bit d, input bit inject);
        logic [767:0] ev;
        logic [383:0] ei;
        int cyc, nb;
        model(va, 50, 50, d, ev, ei);
        qCi.push_back(ei[299:0]);
        qCv.push_back(ev[599:0]);
        loadC(d);
        cyc = 0; nb = 0;
        while (!doneC && cyc < 200) begin
            if (busyC) nb++;
            if (inject && cyc == 5) begin
                startC = 1'b1;
                for (int i = 0; i < 50; i++) inC[12*i +: 12] = 12'($urandom_range(0, 4095));
            end else begin
                startC = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        startC = 1'b0;
        chk("C_done_latency", 768'(cyc), 768'(50));
        chk("C_busy_cycles", 768'(nb), 768'(50));
    endtask

    task automatic randfill();
        int m;
        m = int'($urandom_range(0, 3));
        for (int i = 0; i < 64; i++) begin
            if (m == 0) va[i] = int'($urandom_range(0, 4095));
            else begin
                case ($urandom_range(0, 3))
                    0: va[i] = int'($urandom_range(0, 4095));
                    1: va[i] = int'($urandom_range(0, 3));
                    2: va[i] = 4095;
                    default: va[i] = 0;
                endcase
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        startA = 1'b0; descA = 1'b0; inA = '0;
        startB = 1'b0; descB = 1'b0; inB = '0;
        startC = 1'b0; descC = 1'b0; inC = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A_idx", 768'(idxA), '0);
        chk("rst_A_val", 768'(valA), '0);
        chk("rst_C_idx", 768'(idxC), '0);
        chk("rst_C_val", 768'(valC), '0);
        chk("rst_busy_done", 768'({busyA, doneA, busyB, doneB, busyC, doneC}), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 64; i++) va[i] = 0;
        va[0] = 30; va[1] = 10; va[2] = 20; va[3] = 5;
        runA(1'b0);
        chk("A_asc_idx_plan", 768'(idxA), 768'({6'd0, 6'd2, 6'd1, 6'd3}));
        chk("A_asc_val_plan", 768'(valA), 768'({12'd30, 12'd20, 12'd10, 12'd5}));
        runA(1'b1);
        chk("A_desc_idx_plan", 768'(idxA), 768'({6'd3, 6'd1, 6'd2, 6'd0}));
        chk("A_desc_val_plan", 768'(valA), 768'({12'd5, 12'd10, 12'd20, 12'd30}));
        va[0] = 4095; va[1] = 7; va[2] = 7; va[3] = 4095;
        runA(1'b0);
        chk("A_tie_asc_idx_plan", 768'(idxA), 768'({6'd3, 6'd0, 6'd2, 6'd1}));
        runA(1'b1);
        chk("A_tie_desc_idx_plan", 768'(idxA), 768'({6'd2, 6'd1, 6'd3, 6'd0}));
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++) va[i] = int'($urandom_range(0, 5)) * 819;
            runA(1'(t));
        end

        for (int i = 0; i < 64; i++) va[i] = (i < 50) ? 1000 - i * 3 : 0;
        runB(1'b0);
        chk("B_topk_idx_plan", 768'(idxB), 768'({6'd47, 6'd48, 6'd49}));
        chk("B_topk_val_plan", 768'(valB), 768'({12'd859, 12'd856, 12'd853}));
        for (int t = 0; t < 10; t++) begin
            randfill();
            runB(1'(t));
        end

        // Reset during the second SELECT cycle.
        randfill();
        loadC(1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy_done", 768'({busyC, doneC}), '0);
        chk("midrst_idx", 768'(idxC), '0);
        chk("midrst_val", 768'(valC), '0);
        @(posedge clk); #1;
        chk("midrst_still_idle", 768'({busyC, doneC}), '0);

        for (int t = 0; t < 1000; t++) begin
            randfill();
            runC(1'($urandom_range(0, 1)), (t % 50) == 7);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("queue_drain", 768'(qAi.size() + qBi.size() + qCi.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
